// File: rtl/mod3_seq_monitor.sv
// mod3_seq_monitor: receive-side lock/flywheel checker for the 2-bit mod-3 sequence 00 -> 01 -> 10 -> 00.
// Optional feature macro SEQ_MON_STICKY_EN adds clr_sticky / err_sticky (latched error indication).
module mod3_seq_monitor #(
    parameter int LOCK_N   = 3,
    parameter int UNLOCK_N = 2,
    parameter int CNT_W    = 8,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_a,
    input  logic             in_b,
    output logic             locked,
    output logic             exp_a,
    output logic             exp_b,
    output logic             err_pulse,
    output logic             illegal_pulse,
    output logic [CNT_W-1:0] cycle_count,
    output logic [ERR_W-1:0] err_count
`ifdef SEQ_MON_STICKY_EN
    ,
    input  logic             clr_sticky,
    output logic             err_sticky
`endif
);

    localparam int MATCH_W = (LOCK_N > 1) ? $clog2(LOCK_N) : 1;
    localparam int MISS_W  = (UNLOCK_N > 1) ? $clog2(UNLOCK_N) : 1;
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_N - 1);
    localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(UNLOCK_N - 1);
    localparam logic [ERR_W-1:0]   ERR_MAX    = {ERR_W{1'b1}};

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    // Successor in the legal cycle; 11 never reaches a caller that uses the result.
    function automatic logic [1:0] nxt_code(input logic [1:0] c);
        logic [1:0] n;
        case (c)
            2'b00:   n = 2'b01;
            2'b01:   n = 2'b10;
            default: n = 2'b00;
        endcase
        return n;
    endfunction

    state_t             state_r, state_s;
    logic [1:0]         prev_r, prev_s;
    logic [1:0]         exp_r, exp_s;
    logic [MATCH_W-1:0] match_r, match_s;
    logic [MISS_W-1:0]  miss_r, miss_s;
    logic               locked_r;
    logic               err_pulse_r, err_pulse_s;
    logic               illegal_pulse_r, illegal_pulse_s;
    logic [CNT_W-1:0]   cycle_r, cycle_s;
    logic [ERR_W-1:0]   errc_r, errc_s;
    logic [1:0]         sample_s;

    assign sample_s = {in_a, in_b};

    // Next-state, flywheel and counter logic; everything holds when in_valid is low.
    always_comb begin
        state_s         = state_r;
        prev_s          = prev_r;
        exp_s           = exp_r;
        match_s         = match_r;
        miss_s          = miss_r;
        err_pulse_s     = 1'b0;
        illegal_pulse_s = 1'b0;
        cycle_s         = cycle_r;
        errc_s          = errc_r;
        if (in_valid) begin
            case (state_r)
                ST_HUNT: begin
                    if (sample_s == 2'b11) begin
                        illegal_pulse_s = 1'b1;
                    end else begin
                        prev_s  = sample_s;
                        match_s = '0;
                        exp_s   = nxt_code(sample_s);
                        state_s = ST_ACQUIRE;
                    end
                end
                ST_ACQUIRE: begin
                    if (sample_s == 2'b11) begin
                        illegal_pulse_s = 1'b1;
                        exp_s           = 2'b00;
                        state_s         = ST_HUNT;
                    end else if (sample_s == nxt_code(prev_r)) begin
                        prev_s = sample_s;
                        exp_s  = nxt_code(sample_s);
                        if (match_r == MATCH_LAST) begin
                            match_s = '0;
                            miss_s  = '0;
                            state_s = ST_LOCKED;
                        end else begin
                            match_s = match_r + MATCH_W'(1);
                        end
                    end else begin
                        // A broken run restarts from this sample; exp is left as it was.
                        prev_s  = sample_s;
                        match_s = '0;
                    end
                end
                ST_LOCKED: begin
                    exp_s = nxt_code(exp_r);
                    if (sample_s == exp_r) begin
                        miss_s = '0;
                        if (sample_s == 2'b00) begin
                            cycle_s = cycle_r + CNT_W'(1);
                        end else begin
                            cycle_s = cycle_r;
                        end
                    end else begin
                        err_pulse_s     = 1'b1;
                        illegal_pulse_s = (sample_s == 2'b11);
                        if (errc_r != ERR_MAX) begin
                            errc_s = errc_r + ERR_W'(1);
                        end else begin
                            errc_s = errc_r;
                        end
                        if (miss_r == MISS_LAST) begin
                            miss_s  = '0;
                            exp_s   = 2'b00;
                            state_s = ST_HUNT;
                        end else begin
                            miss_s = miss_r + MISS_W'(1);
                        end
                    end
                end
                default: begin
                    state_s = ST_HUNT;
                    exp_s   = 2'b00;
                    match_s = '0;
                    miss_s  = '0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State, flywheel and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= ST_HUNT;
            prev_r          <= 2'b00;
            exp_r           <= 2'b00;
            match_r         <= '0;
            miss_r          <= '0;
            locked_r        <= 1'b0;
            err_pulse_r     <= 1'b0;
            illegal_pulse_r <= 1'b0;
            cycle_r         <= '0;
            errc_r          <= '0;
        end else begin
            state_r         <= state_s;
            prev_r          <= prev_s;
            exp_r           <= exp_s;
            match_r         <= match_s;
            miss_r          <= miss_s;
            locked_r        <= (state_s == ST_LOCKED);
            err_pulse_r     <= err_pulse_s;
            illegal_pulse_r <= illegal_pulse_s;
            cycle_r         <= cycle_s;
            errc_r          <= errc_s;
        end
    end

    assign locked        = locked_r;
    assign exp_a         = exp_r[1];
    assign exp_b         = exp_r[0];
    assign err_pulse     = err_pulse_r;
    assign illegal_pulse = illegal_pulse_r;
    assign cycle_count   = cycle_r;
    assign err_count     = errc_r;

`ifdef SEQ_MON_STICKY_EN
    logic sticky_r, sticky_s;

    // Sticky flag: a new error outranks a clear arriving on the same edge.
    always_comb begin
        sticky_s = sticky_r;
        if (err_pulse_s || illegal_pulse_s) begin
            sticky_s = 1'b1;
        end else if (clr_sticky) begin
            sticky_s = 1'b0;
        end else begin
            sticky_s = sticky_r;
        end
    end

    // Sticky flag register.
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_r <= 1'b0;
        end else begin
            sticky_r <= sticky_s;
        end
    end

    assign err_sticky = sticky_r;
`endif

endmodule

// File: tb/tb_mod3_seq_monitor.sv
// Self-checking bench for mod3_seq_monitor: directed scenarios plus randomized traffic against a
// sequence-level reference model. dut1 uses default widths, dut2 uses CNT_W=2 / ERR_W=2.
module tb_mod3_seq_monitor;

    localparam int LOCK_N   = 3;
    localparam int UNLOCK_N = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0;
    logic in_a = 1'b0;
    logic in_b = 1'b0;

    logic       locked1, exp_a1, exp_b1, err1, ill1;
    logic [7:0] cyc1, errc1;
    logic       locked2, exp_a2, exp_b2, err2, ill2;
    logic [1:0] cyc2, errc2;
`ifdef SEQ_MON_STICKY_EN
    logic clr_sticky = 1'b0;
    logic sticky1, sticky2;
`endif

    mod3_seq_monitor #(.LOCK_N(LOCK_N), .UNLOCK_N(UNLOCK_N), .CNT_W(8), .ERR_W(8)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
        .locked(locked1), .exp_a(exp_a1), .exp_b(exp_b1), .err_pulse(err1),
        .illegal_pulse(ill1), .cycle_count(cyc1), .err_count(errc1)
`ifdef SEQ_MON_STICKY_EN
        , .clr_sticky(clr_sticky), .err_sticky(sticky1)
`endif
    );

    mod3_seq_monitor #(.LOCK_N(LOCK_N), .UNLOCK_N(UNLOCK_N), .CNT_W(2), .ERR_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
        .locked(locked2), .exp_a(exp_a2), .exp_b(exp_b2), .err_pulse(err2),
        .illegal_pulse(ill2), .cycle_count(cyc2), .err_count(errc2)
`ifdef SEQ_MON_STICKY_EN
        , .clr_sticky(clr_sticky), .err_sticky(sticky2)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;

    // Reference model: sequence-level view of the monitor.
    int m_locked, m_have_prev, m_prev, m_run, m_exp, m_misses, m_cycles, m_errs, m_sticky;
    int m_err, m_ill;

    task automatic model_reset();
        m_locked = 0; m_have_prev = 0; m_prev = 0; m_run = 0; m_exp = 0;
        m_misses = 0; m_cycles = 0; m_errs = 0; m_err = 0; m_ill = 0; m_sticky = 0;
    endtask

    task automatic model_step(input bit v, input int s);
        m_err = 0;
        m_ill = 0;
        if (v) begin
            if (m_locked != 0) begin
                if (s == m_exp) begin
                    m_misses = 0;
                    if (s == 0) m_cycles++;
                end else begin
                    m_err = 1;
                    m_ill = (s == 3) ? 1 : 0;
                    m_errs++;
                    m_misses++;
                end
                m_exp = (m_exp + 1) % 3;
                if (m_misses == UNLOCK_N) begin
                    m_locked = 0; m_have_prev = 0; m_exp = 0; m_misses = 0;
                end
            end else if (m_have_prev == 0) begin
                if (s == 3) m_ill = 1;
                else begin
                    m_have_prev = 1; m_prev = s; m_run = 0; m_exp = (s + 1) % 3;
                end
            end else begin
                if (s == 3) begin
                    m_ill = 1; m_have_prev = 0; m_exp = 0;
                end else if (s == (m_prev + 1) % 3) begin
                    m_run++; m_prev = s; m_exp = (s + 1) % 3;
                    if (m_run == LOCK_N) begin
                        m_locked = 1; m_misses = 0;
                    end
                end else begin
                    m_prev = s; m_run = 0;
                end
            end
        end
`ifdef SEQ_MON_STICKY_EN
        if (m_err != 0 || m_ill != 0) m_sticky = 1;
        else if (clr_sticky) m_sticky = 0;
`endif
    endtask

    function automatic int exp_cyc(input int w);
        return m_cycles % (1 << w);
    endfunction

    function automatic int exp_errc(input int w);
        return (m_errs > (1 << w) - 1) ? (1 << w) - 1 : m_errs;
    endfunction

    // One clock: drive inputs, advance the model at the edge, settle 1 time unit after it.
    task automatic step(input bit v, input int s);
        int sv;
        sv = s;
        in_valid = v;
        {in_a, in_b} = sv[1:0];
        @(posedge clk);
        if (reset) model_reset();
        else model_step(v, s);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(1'b1, 2);
        reset = 1'b0;
        n_checks++; if (locked1 !== 1'b0) $display("FAIL reset_locked got=%0b want=0", locked1); else n_pass++;
        n_checks++; if ({exp_a1, exp_b1} !== 2'b00) $display("FAIL reset_exp got=%b want=00", {exp_a1, exp_b1}); else n_pass++;
        n_checks++; if ({err1, ill1, err2, ill2} !== 4'b0000) $display("FAIL reset_pulses got=%b want=0000", {err1, ill1, err2, ill2}); else n_pass++;
        n_checks++; if ({cyc1, errc1, cyc2, errc2} !== 20'd0) $display("FAIL reset_counts got=%h want=0", {cyc1, errc1, cyc2, errc2}); else n_pass++;
    endtask

    task automatic test_lock();
        step(1'b1, 0); step(1'b1, 1); step(1'b1, 2);
        n_checks++; if (locked1 !== 1'b0) $display("FAIL lock_early got=%0b want=0", locked1); else n_pass++;
        step(1'b1, 0);
        n_checks++; if (locked1 !== 1'b1) $display("FAIL lock_locked got=%0b want=1", locked1); else n_pass++;
        n_checks++; if ({exp_a1, exp_b1} !== 2'b01) $display("FAIL lock_exp got=%b want=01", {exp_a1, exp_b1}); else n_pass++;
        n_checks++; if (cyc1 !== 8'd0) $display("FAIL lock_cycles got=%0d want=0", cyc1); else n_pass++;
        n_checks++; if ({err1, ill1, errc1} !== 10'd0) $display("FAIL lock_errs got=%h want=0", {err1, ill1, errc1}); else n_pass++;
    endtask

    task automatic test_cycle_count();
        bit saw_err;
        saw_err = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1); saw_err |= err1;
            step(1'b1, 2); saw_err |= err1;
            step(1'b1, 0); saw_err |= err1;
        end
        n_checks++; if (cyc1 !== 8'd5) $display("FAIL cyc_count got=%0d want=5", cyc1); else n_pass++;
        n_checks++; if (cyc2 !== 2'd1) $display("FAIL cyc_wrap got=%0d want=1", cyc2); else n_pass++;
        n_checks++; if (saw_err !== 1'b0) $display("FAIL cyc_no_err got=%0b want=0", saw_err); else n_pass++;
        n_checks++; if (locked1 !== 1'b1) $display("FAIL cyc_locked got=%0b want=1", locked1); else n_pass++;
    endtask

    task automatic test_unlock();
        step(1'b1, 2);
        n_checks++; if (err1 !== 1'b1) $display("FAIL unlock1_err got=%0b want=1", err1); else n_pass++;
        n_checks++; if (errc1 !== 8'd1) $display("FAIL unlock1_errc got=%0d want=1", errc1); else n_pass++;
        n_checks++; if (locked1 !== 1'b1) $display("FAIL unlock1_locked got=%0b want=1", locked1); else n_pass++;
        n_checks++; if ({exp_a1, exp_b1} !== 2'b10) $display("FAIL unlock1_exp got=%b want=10", {exp_a1, exp_b1}); else n_pass++;
        step(1'b1, 0);
        n_checks++; if (err1 !== 1'b1) $display("FAIL unlock2_err got=%0b want=1", err1); else n_pass++;
        n_checks++; if (errc1 !== 8'd2) $display("FAIL unlock2_errc got=%0d want=2", errc1); else n_pass++;
        n_checks++; if (locked1 !== 1'b0) $display("FAIL unlock2_locked got=%0b want=0", locked1); else n_pass++;
        n_checks++; if ({exp_a1, exp_b1} !== 2'b00) $display("FAIL unlock2_exp got=%b want=00", {exp_a1, exp_b1}); else n_pass++;
    endtask

    task automatic test_illegal();
        step(1'b1, 3);
        n_checks++; if ({ill1, err1} !== 2'b10) $display("FAIL ill_hunt_pulses got=%b want=10", {ill1, err1}); else n_pass++;
        n_checks++; if ({locked1, exp_a1, exp_b1} !== 3'b000) $display("FAIL ill_hunt_state got=%b want=000", {locked1, exp_a1, exp_b1}); else n_pass++;
        n_checks++; if (errc1 !== 8'd2) $display("FAIL ill_hunt_errc got=%0d want=2", errc1); else n_pass++;
        step(1'b1, 0); step(1'b1, 1); step(1'b1, 2); step(1'b1, 0);
        step(1'b1, 3);
        n_checks++; if ({ill1, err1} !== 2'b11) $display("FAIL ill_lock_pulses got=%b want=11", {ill1, err1}); else n_pass++;
        n_checks++; if (errc1 !== 8'd3) $display("FAIL ill_lock_errc got=%0d want=3", errc1); else n_pass++;
        n_checks++; if (errc2 !== 2'd3) $display("FAIL ill_lock_errc_sat got=%0d want=3", errc2); else n_pass++;
        n_checks++; if (locked1 !== 1'b1) $display("FAIL ill_lock_locked got=%0b want=1", locked1); else n_pass++;
    endtask

    task automatic test_gaps();
        logic [19:0] snap;
        step(1'b1, 2);
        n_checks++; if (err1 !== 1'b0) $display("FAIL gap_resync_err got=%0b want=0", err1); else n_pass++;
        snap = {locked1, exp_a1, exp_b1, cyc1, errc1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            step(1'b0, $urandom_range(3));
            n_checks++; if ({locked1, exp_a1, exp_b1, cyc1, errc1, 1'b0} !== snap) $display("FAIL gap_hold got=%h want=%h", {locked1, exp_a1, exp_b1, cyc1, errc1, 1'b0}, snap); else n_pass++;
            n_checks++; if ({err1, ill1} !== 2'b00) $display("FAIL gap_pulses got=%b want=00", {err1, ill1}); else n_pass++;
        end
        n_checks++; if (snap[19] !== 1'(m_locked)) $display("FAIL gap_model_locked got=%0b want=%0d", snap[19], m_locked); else n_pass++;
    endtask

    task automatic test_reset_midseq();
        step(1'b1, 0);
        reset = 1'b1;
        step(1'b1, 1);
        reset = 1'b0;
        n_checks++; if ({locked1, exp_a1, exp_b1, err1, ill1} !== 5'd0) $display("FAIL rst_mid_flags got=%b want=00000", {locked1, exp_a1, exp_b1, err1, ill1}); else n_pass++;
        n_checks++; if ({cyc1, errc1} !== 16'd0) $display("FAIL rst_mid_counts got=%h want=0", {cyc1, errc1}); else n_pass++;
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 0); step(1'b1, 1); step(1'b1, 2); step(1'b1, 0);
            for (int j = 0; j < ((k < 2) ? 2 : 1); j++) step(1'b1, (m_exp + 1) % 3);
        end
        n_checks++; if (errc2 !== 2'd3) $display("FAIL sat_errc2 got=%0d want=3", errc2); else n_pass++;
        n_checks++; if (errc1 !== 8'd5) $display("FAIL sat_errc1 got=%0d want=5", errc1); else n_pass++;
        n_checks++; if (locked1 !== 1'b1) $display("FAIL sat_locked got=%0b want=1", locked1); else n_pass++;
    endtask

    task automatic test_random();
        int last, r, s;
        bit v;
        last = 0;
        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(99) < 2);
            v = ($urandom_range(3) != 0);
            r = $urandom_range(19);
            s = (r < 16) ? (last + 1) % 3 : (r < 18) ? $urandom_range(2) : 3;
            if (v && s != 3) last = s;
            step(v, s);
            reset = 1'b0;
            n_checks++; if (locked1 !== 1'(m_locked) || locked2 !== 1'(m_locked)) $display("FAIL rnd_locked c=%0d got=%0b%0b want=%0d", c, locked1, locked2, m_locked); else n_pass++;
            n_checks++; if ({exp_a1, exp_b1} !== 2'(m_exp) || {exp_a2, exp_b2} !== 2'(m_exp)) $display("FAIL rnd_exp c=%0d got=%b want=%0d", c, {exp_a1, exp_b1}, m_exp); else n_pass++;
            n_checks++; if (err1 !== 1'(m_err) || err2 !== 1'(m_err)) $display("FAIL rnd_err c=%0d got=%0b want=%0d", c, err1, m_err); else n_pass++;
            n_checks++; if (ill1 !== 1'(m_ill) || ill2 !== 1'(m_ill)) $display("FAIL rnd_ill c=%0d got=%0b want=%0d", c, ill1, m_ill); else n_pass++;
            n_checks++; if (cyc1 !== 8'(exp_cyc(8)) || cyc2 !== 2'(exp_cyc(2))) $display("FAIL rnd_cyc c=%0d got=%0d/%0d want=%0d", c, cyc1, cyc2, m_cycles); else n_pass++;
            n_checks++; if (errc1 !== 8'(exp_errc(8)) || errc2 !== 2'(exp_errc(2))) $display("FAIL rnd_errc c=%0d got=%0d/%0d want=%0d", c, errc1, errc2, m_errs); else n_pass++;
        end
    endtask

`ifdef SEQ_MON_STICKY_EN
    task automatic test_sticky();
        reset = 1'b1; step(1'b0, 0); reset = 1'b0;
        n_checks++; if (sticky1 !== 1'b0) $display("FAIL sticky_reset got=%0b want=0", sticky1); else n_pass++;
        step(1'b1, 3);
        n_checks++; if (sticky1 !== 1'b1) $display("FAIL sticky_set got=%0b want=1", sticky1); else n_pass++;
        step(1'b0, 0); step(1'b0, 0);
        n_checks++; if (sticky1 !== 1'b1) $display("FAIL sticky_hold got=%0b want=1", sticky1); else n_pass++;
        clr_sticky = 1'b1; step(1'b0, 0); clr_sticky = 1'b0;
        n_checks++; if (sticky1 !== 1'b0) $display("FAIL sticky_clr got=%0b want=0", sticky1); else n_pass++;
        clr_sticky = 1'b1; step(1'b1, 3); clr_sticky = 1'b0;
        n_checks++; if (sticky1 !== 1'b1 || sticky2 !== 1'(m_sticky)) $display("FAIL sticky_set_wins got=%0b want=1", sticky1); else n_pass++;
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_lock();
        test_cycle_count();
        test_unlock();
        test_illegal();
        test_gaps();
        test_reset_midseq();
        test_saturation();
        test_random();
`ifdef SEQ_MON_STICKY_EN
        test_sticky();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
